cla_add_arbiter: RTL and testbench
==================================

CLA_ADD_ARBITER -- requirements
Module: cla_add_arbiter

Interface
REQ-001 The parameters SHALL be:
- LATENCY, default 5: adder operand-to-sum register depth.
- The requester count is fixed at 2.

REQ-002 The ports SHALL be:

| Name | Dir | Width | Meaning |
|---|---|---|---|
| i_clk | in | 1 | single clock; all logic on rising edge |
| i_rst_n | in | 1 | reset, synchronous, active-low |
| reqN_valid (N=0,1) | in | 1 | requester N has an add pending |
| reqN_ready | out | 1 | requester N accepted this cycle |
| reqN_a, reqN_b | in | 32 | operands; only [15:0] used when narrow |
| reqN_cin | in | 1 | carry-in |
| reqN_wide | in | 1 | 1 = 32-bit add, 0 = 16-bit add |
| rspN_valid | out | 1 | one-cycle result strobe to requester N; no backpressure |
| rspN_sum | out | 32 | result |
| rspN_cout | out | 1 | carry-out |
| add_a, add_b | out | 16 | registered operands to the shared pipelined adder |
| add_cin | out | 1 | registered carry-in to the adder |
| add_sum | in | 16 | adder result |
| add_cout | in | 1 | adder carry-out |

Function
REQ-003 The block SHALL share one LATENCY-deep pipelined 16-bit CLA adder between two requesters and return each result only to the requester that issued it.

REQ-004 The FSM SHALL have three states:
- IDLE: grants allowed.
- WIDE_WAIT: low half in flight, no grants.
- WIDE_HI: high half issued, no grants.

REQ-005 In IDLE, reqN_ready SHALL be high only for the grantee. The grantee is chosen by round-robin over valid requesters. The pointer resets to favour requester 0 and toggles after every accept. reqN_ready may depend combinationally on reqN_valid.

REQ-006 In WIDE_WAIT and WIDE_HI, both reqN_ready outputs SHALL be 0.

REQ-007 On an accept edge E:
- add_a/add_b SHALL take a[15:0]/b[15:0] at edge E.
- add_cin SHALL take cin at edge E+1, so carry-in lags operands by exactly one cycle.

REQ-008 When no issue occurs, add_a/add_b SHALL be driven 0, and add_cin SHALL be driven 0 one cycle later.

REQ-009 A tag pipeline SHALL follow every issue in step with the adder. Each tag holds valid, requester id, and kind (NARROW, LO, HI). A tag reaches the output stage when add_sum/add_cout for that issue are valid, i.e. after edge E+LATENCY.

REQ-010 For a NARROW tag, the block SHALL register at the next edge:
- rspN_sum = {16'h0, add_sum}
- rspN_cout = add_cout
- rspN_valid = 1 for one cycle

Response latency SHALL be LATENCY+1 edges after accept (6 by default).

REQ-011 For a wide accept, the block SHALL:
1. Issue the low half and capture a[31:16], b[31:16] and the requester id.
2. Enter WIDE_WAIT.
3. When the LO tag returns, capture add_sum as sum[15:0] and add_cout as the carry.
4. Issue the high half on that same edge, with add_cin the following cycle equal to the captured carry.
5. Enter WIDE_HI.

REQ-012 When the HI tag returns, the block SHALL register:
- rspN_sum = {add_sum, low}
- rspN_cout = add_cout
- rspN_valid for one cycle

The FSM SHALL then return to IDLE. Wide response latency SHALL be 2*(LATENCY+1) edges after accept (12 by default).

REQ-013 Narrow ops issued before a wide accept SHALL still drain and respond normally while the FSM is in WIDE_WAIT or WIDE_HI.

REQ-014 Narrow accepts SHALL sustain one issue per cycle back-to-back.

REQ-015 At most one rspN_valid SHALL be high in any cycle.

REQ-016 A requester dropping reqN_valid before acceptance SHALL cause no issue.

REQ-017 rspN_sum/rspN_cout SHALL hold their last value while rspN_valid is 0.

Reset
REQ-018 While i_rst_n=0 at an edge, the block SHALL set:
- FSM to IDLE and round-robin pointer to requester 0.
- All tag valids, rspN_valid, reqN_ready, add_a, add_b and add_cin to 0.
- rspN_sum and rspN_cout to 0.

REQ-019 Reset mid-operation SHALL discard all in-flight tags and any partial wide result. No rspN_valid SHALL assert for work accepted before reset, even though the adder pipeline still carries that data.

REQ-020 The first accept SHALL be possible in the first cycle after i_rst_n returns to 1.

Structure
REQ-021 A shared package SHALL hold:
- the FSM state enum (IDLE, WIDE_WAIT, WIDE_HI);
- the tag kind enum (NARROW, LO, HI);
- the tag struct (valid, id, kind);
- the LATENCY default constant.

REQ-022 The two-way round-robin grant SHALL be one sub-module, rr_arb_2.

REQ-023 The adder itself SHALL NOT be instantiated inside this block; the parent SHALL connect the add_* ports to cla_16bit.

Verification
REQ-024 The bench SHALL cover these directed scenarios:

| Scenario | Stimulus | Required response |
|---|---|---|
| Single narrow | req0 narrow a=16'hFFFF, b=16'h0001, cin=0 | rsp0_valid 6 cycles after accept, sum=32'h0000_0000, cout=1 |
| Single wide | req1 wide a=32'h0000_FFFF, b=32'h0000_0001, cin=0 | rsp1_valid 12 cycles after accept, sum=32'h0001_0000, cout=0; ready low for 11 cycles after accept |
| Contention | both valid for 4 cycles, narrow | grants alternate 0,1,0,1; responses 6 cycles after each accept go to the matching port; never both rspN_valid in one cycle |
| Mixed | req0 narrow accepted, then req1 wide the next cycle | rsp0 at +6, rsp1 at +12 from its own accept; no grant during WIDE_WAIT/WIDE_HI |
| Reset mid-wide | assert i_rst_n=0 for one cycle, 3 cycles after a wide accept | no rspN_valid afterwards; new narrow accept the cycle after release responds correctly at +6 |
| Carry lag | narrow cin=1, a=b=0 | add_cin=1 exactly one cycle after add_a update; sum=1 |

Source files
------------

// File: rtl/cla_add_arbiter_pkg.sv
// rtl/cla_add_arbiter_pkg.sv - shared types and constants for the two-requester adder arbiter
package cla_add_arbiter_pkg;

  localparam int LATENCY_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WIDE_WAIT = 2'd1,
    ST_WIDE_HI   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    KIND_NARROW = 2'd0,
    KIND_LO     = 2'd1,
    KIND_HI     = 2'd2
  } kind_t;

  typedef struct packed {
    logic  valid;
    logic  id;
    kind_t kind;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, id: 1'b0, kind: KIND_NARROW};

  function automatic tag_t make_tag(input logic id, input kind_t kind);
    tag_t t;
    t.valid = 1'b1;
    t.id    = id;
    t.kind  = kind;
    return t;
  endfunction

endpackage

// File: rtl/rr_arb_2.sv
// rtl/rr_arb_2.sv - two-way round-robin grant with a pointer that toggles on every accept
module rr_arb_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic ptr;

  // favoured requester wins when valid, otherwise the other valid requester
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid[0] && (!ptr || !valid[1])) begin
        grant = 2'b01;
      end else if (valid[1]) begin
        grant = 2'b10;
      end
    end
  end

  // pointer starts favouring requester 0 and flips after each accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (|grant) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/cla_add_arbiter.sv
// rtl/cla_add_arbiter.sv - shares one external pipelined 16-bit adder between two requesters
module cla_add_arbiter
  import cla_add_arbiter_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_cin,
  input  logic        req0_wide,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_cin,
  input  logic        req1_wide,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_sum,
  output logic        rsp0_cout,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_sum,
  output logic        rsp1_cout,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_sum,
  input  logic        add_cout
);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  grant;
  logic        grant_en;
  logic        acc;
  logic        acc_id;
  logic [31:0] acc_a;
  logic [31:0] acc_b;
  logic        acc_cin;
  logic        acc_wide;

  tag_t        tag_q [0:LATENCY];
  tag_t        ret_tag;
  tag_t        issue_tag;
  logic [15:0] issue_a;
  logic [15:0] issue_b;
  logic        issue_cin;
  logic        cin_pend;

  logic [15:0] hi_a;
  logic [15:0] hi_b;
  logic [15:0] low_sum;
  logic        wide_id;
  logic        lo_return;
  logic        hi_return;

  logic        rsp_fire;
  logic [31:0] rsp_sum_d;

  // grants only while idle and out of reset
  assign grant_en = i_rst_n && (state == ST_IDLE);

  rr_arb_2 u_arb (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .enable (grant_en),
    .valid  ({req1_valid, req0_valid}),
    .grant  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // select the accepted requester's operands
  always_comb begin
    acc      = grant[0] | grant[1];
    acc_id   = grant[1];
    acc_a    = acc_id ? req1_a    : req0_a;
    acc_b    = acc_id ? req1_b    : req0_b;
    acc_cin  = acc_id ? req1_cin  : req0_cin;
    acc_wide = acc_id ? req1_wide : req0_wide;
  end

  // the tag at the end of the pipe lines up with add_sum/add_cout
  assign ret_tag   = tag_q[LATENCY];
  assign lo_return = ret_tag.valid && (ret_tag.kind == KIND_LO) && (state == ST_WIDE_WAIT);
  assign hi_return = ret_tag.valid && (ret_tag.kind == KIND_HI) && (state == ST_WIDE_HI);

  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and issue selection: new accepts in IDLE, high half when the low half returns
  always_comb begin
    state_nxt = state;
    issue_a   = 16'h0000;
    issue_b   = 16'h0000;
    issue_cin = 1'b0;
    issue_tag = TAG_NONE;
    case (state)
      ST_IDLE: begin
        if (acc) begin
          issue_a   = acc_a[15:0];
          issue_b   = acc_b[15:0];
          issue_cin = acc_cin;
          issue_tag = make_tag(acc_id, acc_wide ? KIND_LO : KIND_NARROW);
          if (acc_wide) begin
            state_nxt = ST_WIDE_WAIT;
          end
        end
      end
      ST_WIDE_WAIT: begin
        if (lo_return) begin
          issue_a   = hi_a;
          issue_b   = hi_b;
          issue_cin = add_cout;
          issue_tag = make_tag(wide_id, KIND_HI);
          state_nxt = ST_WIDE_HI;
        end
      end
      ST_WIDE_HI: begin
        if (hi_return) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // adder drive: operands at the issue edge, carry-in one edge later
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      add_a    <= 16'h0000;
      add_b    <= 16'h0000;
      cin_pend <= 1'b0;
      add_cin  <= 1'b0;
    end else begin
      add_a    <= issue_a;
      add_b    <= issue_b;
      cin_pend <= issue_cin;
      add_cin  <= cin_pend;
    end
  end

  // tag pipeline tracking every issue in step with the adder
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= LATENCY; i++) begin
        tag_q[i] <= TAG_NONE;
      end
    end else begin
      tag_q[0] <= issue_tag;
      for (int i = 1; i <= LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // wide context: upper operands and owner at accept, low result when it returns
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hi_a    <= 16'h0000;
      hi_b    <= 16'h0000;
      wide_id <= 1'b0;
      low_sum <= 16'h0000;
    end else begin
      if ((state == ST_IDLE) && acc && acc_wide) begin
        hi_a    <= acc_a[31:16];
        hi_b    <= acc_b[31:16];
        wide_id <= acc_id;
      end
      if (lo_return) begin
        low_sum <= add_sum;
      end
    end
  end

  // result formatting for narrow and high-half returns
  always_comb begin
    rsp_fire  = 1'b0;
    rsp_sum_d = {16'h0000, add_sum};
    if (ret_tag.valid && (ret_tag.kind == KIND_NARROW)) begin
      rsp_fire = 1'b1;
    end else if (hi_return) begin
      rsp_fire  = 1'b1;
      rsp_sum_d = {add_sum, low_sum};
    end
  end

  // response registers: one-cycle strobe to the owner, data held otherwise
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rsp0_valid <= 1'b0;
      rsp0_sum   <= 32'h0;
      rsp0_cout  <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_sum   <= 32'h0;
      rsp1_cout  <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (rsp_fire && !ret_tag.id) begin
        rsp0_valid <= 1'b1;
        rsp0_sum   <= rsp_sum_d;
        rsp0_cout  <= add_cout;
      end
      if (rsp_fire && ret_tag.id) begin
        rsp1_valid <= 1'b1;
        rsp1_sum   <= rsp_sum_d;
        rsp1_cout  <= add_cout;
      end
    end
  end

endmodule

// File: tb/tb_cla_add_arbiter.sv
// tb/tb_cla_add_arbiter.sv - directed self-checking bench for cla_add_arbiter
module tb_cla_add_arbiter;

  localparam int LAT  = 5;
  localparam int LOGN = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin, req0_wide;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin, req1_wide;
  logic [31:0] req1_a, req1_b;
  logic        rsp0_valid, rsp0_cout, rsp1_valid, rsp1_cout;
  logic [31:0] rsp0_sum, rsp1_sum;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int acc_edge [$];
  int acc_id   [$];

  logic        lv0 [0:LOGN-1];
  logic        lv1 [0:LOGN-1];
  logic [31:0] ls0 [0:LOGN-1];
  logic [31:0] ls1 [0:LOGN-1];
  logic        lc0 [0:LOGN-1];
  logic        lc1 [0:LOGN-1];
  logic [15:0] la  [0:LOGN-1];
  logic [15:0] lb  [0:LOGN-1];
  logic        lci [0:LOGN-1];
  logic        lr1 [0:LOGN-1];

  always #5 clk = ~clk;

  cla_add_arbiter #(.LATENCY(LAT)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req0_wide  (req0_wide),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .req1_wide  (req1_wide),
    .rsp0_valid (rsp0_valid),
    .rsp0_sum   (rsp0_sum),
    .rsp0_cout  (rsp0_cout),
    .rsp1_valid (rsp1_valid),
    .rsp1_sum   (rsp1_sum),
    .rsp1_cout  (rsp1_cout),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_sum    (add_sum),
    .add_cout   (add_cout)
  );

  // adder model: operands registered, carry-in joins one stage later, result after LAT edges
  logic [15:0] s1_a = 16'h0, s1_b = 16'h0;
  logic [16:0] res_q [2:LAT];
  initial for (int k = 2; k <= LAT; k++) res_q[k] = 17'h0;
  always @(posedge clk) begin
    s1_a     <= add_a;
    s1_b     <= add_b;
    res_q[2] <= {1'b0, s1_a} + {1'b0, s1_b} + {16'h0, add_cin};
    for (int k = 3; k <= LAT; k++) res_q[k] <= res_q[k-1];
  end
  assign add_sum  = res_q[LAT][15:0];
  assign add_cout = res_q[LAT][16];

  // accept recorder and edge counter
  always @(posedge clk) begin
    if (req0_valid && req0_ready) begin acc_edge.push_back(cyc + 1); acc_id.push_back(0); end
    if (req1_valid && req1_ready) begin acc_edge.push_back(cyc + 1); acc_id.push_back(1); end
    cyc <= cyc + 1;
  end

  // per-edge log of outputs, sampled on the falling edge
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      lv0[cyc] = rsp0_valid; ls0[cyc] = rsp0_sum; lc0[cyc] = rsp0_cout;
      lv1[cyc] = rsp1_valid; ls1[cyc] = rsp1_sum; lc1[cyc] = rsp1_cout;
      la[cyc]  = add_a; lb[cyc] = add_b; lci[cyc] = add_cin; lr1[cyc] = req1_ready;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int last_edge();
    return (acc_edge.size() > 0) ? acc_edge[acc_edge.size()-1] : -1;
  endfunction

  function automatic int rsp_count(input int port, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) begin
      if (port == 0 && lv0[i] === 1'b1) n++;
      if (port == 1 && lv1[i] === 1'b1) n++;
    end
    return n;
  endfunction

  task automatic chk_rsp(input string tag, input int port, input int e, input logic [31:0] sum, input logic cout);
    if (port == 0) begin
      chk({tag, "_v"}, lv0[e], 1'b1);
      chk({tag, "_sum"}, ls0[e], sum);
      chk({tag, "_cout"}, lc0[e], cout);
      chk({tag, "_other"}, lv1[e], 1'b0);
    end else begin
      chk({tag, "_v"}, lv1[e], 1'b1);
      chk({tag, "_sum"}, ls1[e], sum);
      chk({tag, "_cout"}, lc1[e], cout);
      chk({tag, "_other"}, lv0[e], 1'b0);
    end
  endtask

  initial begin
    int e, e0, e1, n0, both;
    logic [31:0] exp_sum [4];
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h0; req0_b = 32'h0; req0_cin = 1'b0; req0_wide = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h0; req1_b = 32'h0; req1_cin = 1'b0; req1_wide = 1'b0;
    step(3);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_add_a", add_a, 16'h0);
    chk("rst_add_cin", add_cin, 1'b0);
    chk("rst_rsp0_v", rsp0_valid, 1'b0);
    chk("rst_rsp0_sum", rsp0_sum, 32'h0);
    chk("rst_rsp1_cout", rsp1_cout, 1'b0);

    // contention from the first cycle after release: grants 0,1,0,1
    rst_n = 1'b1;
    e0 = cyc + 1;
    n0 = acc_edge.size();
    for (int i = 0; i < 4; i++) begin
      req0_a = 32'h1000 + i; req0_b = 32'h0100;
      req1_a = 32'h2000 + i; req1_b = 32'h0200;
      step(1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(10);
    exp_sum[0] = 32'h1100; exp_sum[1] = 32'h2201; exp_sum[2] = 32'h1102; exp_sum[3] = 32'h2203;
    chk("cont_acc_count", acc_edge.size() - n0, 4);
    if (acc_edge.size() - n0 == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("cont_id%0d", i), acc_id[n0+i], i % 2);
        chk($sformatf("cont_edge%0d", i), acc_edge[n0+i], e0 + i);
        chk_rsp($sformatf("cont_rsp%0d", i), i % 2, e0 + i + 6, exp_sum[i], 1'b0);
      end
    end
    chk("cont_hold_v", lv1[e0 + 10], 1'b0);
    chk("cont_hold_sum", ls1[e0 + 10], 32'h2203);

    // single narrow: FFFF + 1
    req0_a = 32'h0000_FFFF; req0_b = 32'h1; req0_cin = 1'b0; req0_wide = 1'b0; req0_valid = 1'b1;
    step(1);
    e = last_edge();
    req0_valid = 1'b0;
    step(9);
    chk("nar_edge", e, cyc - 9);
    chk("nar_add_a", la[e], 16'hFFFF);
    chk("nar_add_b", lb[e], 16'h0001);
    chk("nar_add_a_idle", la[e+1], 16'h0);
    chk_rsp("nar", 0, e + 6, 32'h0, 1'b1);
    chk("nar_rsp_count", rsp_count(0, e + 1, e + 9), 1);

    // carry lag: cin follows the operands by exactly one cycle
    req0_a = 32'h0; req0_b = 32'h0; req0_cin = 1'b1; req0_valid = 1'b1;
    step(1);
    e = last_edge();
    req0_valid = 1'b0; req0_cin = 1'b0;
    step(8);
    chk("lag_cin_e0", lci[e], 1'b0);
    chk("lag_cin_e1", lci[e+1], 1'b1);
    chk("lag_cin_e2", lci[e+2], 1'b0);
    chk_rsp("lag", 0, e + 6, 32'h1, 1'b0);

    // single wide from requester 1, ready held low while busy
    req1_a = 32'h0000_FFFF; req1_b = 32'h1; req1_cin = 1'b0; req1_wide = 1'b1; req1_valid = 1'b1;
    n0 = acc_edge.size();
    step(1);
    e = last_edge();
    step(11);
    req1_valid = 1'b0;
    step(3);
    chk("wide_accepts", acc_edge.size() - n0, 1);
    n0 = 0;
    for (int i = 0; i <= 10; i++) if (lr1[e+i] !== 1'b0) n0++;
    chk("wide_ready_low", n0, 0);
    chk("wide_early", rsp_count(1, e + 1, e + 11), 0);
    chk_rsp("wide", 1, e + 12, 32'h0001_0000, 1'b0);
    chk("wide_rsp0_none", rsp_count(0, e + 1, e + 14), 0);

    // mixed: narrow on 0, wide on 1 the next cycle, req0 held during the wide op
    req0_a = 32'h0000_ABCD; req0_b = 32'h0000_1111; req0_cin = 1'b1; req0_wide = 1'b0; req0_valid = 1'b1;
    step(1);
    e0 = last_edge();
    req0_valid = 1'b0;
    req1_a = 32'h1234_8000; req1_b = 32'h0001_8000; req1_cin = 1'b1; req1_wide = 1'b1; req1_valid = 1'b1;
    n0 = acc_edge.size();
    step(1);
    e1 = last_edge();
    req1_valid = 1'b0; req0_valid = 1'b1;
    step(11);
    req0_valid = 1'b0;
    step(4);
    chk("mix_edges", e1 - e0, 1);
    chk("mix_no_grant", acc_edge.size() - n0, 1);
    chk_rsp("mix_nar", 0, e0 + 6, 32'h0000_BCDF, 1'b0);
    chk_rsp("mix_wide", 1, e1 + 12, 32'h1236_0001, 1'b0);
    chk("mix_rsp1_count", rsp_count(1, e1 + 1, e1 + 15), 1);

    // reset three cycles after a wide accept
    req1_a = 32'h0000_0001; req1_b = 32'h0000_0001; req1_wide = 1'b1; req1_cin = 1'b0; req1_valid = 1'b1;
    step(1);
    e = last_edge();
    req1_valid = 1'b0;
    step(3);
    rst_n = 1'b0;
    step(1);
    chk("rmid_add_a", add_a, 16'h0);
    chk("rmid_rsp1_v", rsp1_valid, 1'b0);
    rst_n = 1'b1;
    req0_a = 32'h5; req0_b = 32'h3; req0_cin = 1'b0; req0_wide = 1'b0; req0_valid = 1'b1;
    step(1);
    chk("rmid_acc_edge", last_edge(), e + 5);
    chk("rmid_acc_id", acc_id[acc_id.size()-1], 0);
    req0_valid = 1'b0;
    step(14);
    chk("rmid_no_rsp1", rsp_count(1, e + 1, e + 19), 0);
    chk("rmid_rsp0_count", rsp_count(0, e + 1, e + 19), 1);
    chk_rsp("rmid_nar", 0, e + 11, 32'h8, 1'b0);

    // never two responses in one cycle
    both = 0;
    for (int i = 0; i < cyc && i < LOGN; i++) if (lv0[i] === 1'b1 && lv1[i] === 1'b1) both++;
    chk("one_rsp_per_cycle", both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
